// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with valid/ready handshake.
// MUL and DIV are held in EXEC for a programmable latency before the code is presented.
module alu_control_seq #(
    parameter int unsigned FUNC_W     = 3,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FUNC_W-1:0] function_input,
    input  logic [1:0]        alu_op,
    output logic [2:0]        alu_control,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              multi_cycle,
    output logic              illegal,
    output logic [CNT_W-1:0]  busy_count
);

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    localparam logic [CNT_W-1:0] MulLatM1 = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DivLatM1 = CNT_W'(DIV_CYCLES - 1);

    state_e           state;
    logic [CNT_W-1:0] count;
    logic [2:0]       dec_code;
    logic             dec_illegal;
    logic [CNT_W-1:0] dec_lat_m1;
    logic             upper_nz;
    logic             accept;
    logic             transfer;

    // Bits above [2:0] must be zero; shifting avoids an empty slice when FUNC_W == 3.
    assign upper_nz = |(function_input >> 3);

    always_comb begin
        dec_code    = 3'b001;
        dec_illegal = 1'b0;
        dec_lat_m1  = '0;
        case (alu_op)
            2'b01: dec_code = 3'b010;
            2'b10: begin
                if (upper_nz) begin
                    dec_code    = 3'b000;
                    dec_illegal = 1'b1;
                end else begin
                    case (function_input[2:0])
                        3'b000: dec_code = 3'b001;
                        3'b010: dec_code = 3'b010;
                        3'b100: dec_code = 3'b011;
                        3'b101: dec_code = 3'b100;
                        3'b110: begin
                            dec_code   = 3'b101;
                            dec_lat_m1 = MulLatM1;
                        end
                        3'b111: begin
                            dec_code   = 3'b110;
                            dec_lat_m1 = DivLatM1;
                        end
                        default: begin
                            dec_code    = 3'b000;
                            dec_illegal = 1'b1;
                        end
                    endcase
                end
            end
            default: dec_code = 3'b001;
        endcase
    end

    assign in_ready   = (state == StIdle) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign transfer   = out_valid && out_ready;
    assign busy_count = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            count       <= '0;
            alu_control <= 3'b000;
            out_valid   <= 1'b0;
            illegal     <= 1'b0;
            multi_cycle <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        alu_control <= dec_code;
                        illegal     <= dec_illegal;
                        if (dec_lat_m1 == '0) begin
                            out_valid <= 1'b1;
                        end else begin
                            out_valid   <= 1'b0;
                            multi_cycle <= 1'b1;
                            count       <= dec_lat_m1;
                            state       <= StExec;
                        end
                    end else if (transfer) begin
                        out_valid <= 1'b0;
                    end
                end
                StExec: begin
                    if (count == CNT_W'(1)) begin
                        out_valid   <= 1'b1;
                        multi_cycle <= 1'b0;
                        count       <= '0;
                        state       <= StIdle;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode table, multi-cycle sequencing,
// back-pressure, wide function field and reset abort.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid, in_ready, out_valid, out_ready, multi_cycle, illegal;
    logic [2:0] function_input, alu_control;
    logic [1:0] alu_op;
    logic [3:0] busy_count;

    // Second instance: 6-bit function field, MUL latency 1, DIV latency 2.
    logic       iv6, ir6, ov6, or6, mc6, ill6;
    logic [5:0] fn6;
    logic [1:0] op6;
    logic [2:0] ac6;
    logic [3:0] bc6;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_control_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .function_input(function_input), .alu_op(alu_op), .alu_control(alu_control),
        .out_valid(out_valid), .out_ready(out_ready), .multi_cycle(multi_cycle),
        .illegal(illegal), .busy_count(busy_count)
    );

    alu_control_seq #(.FUNC_W(6), .MUL_CYCLES(1), .DIV_CYCLES(2), .CNT_W(4)) dut6 (
        .clk(clk), .reset(reset), .in_valid(iv6), .in_ready(ir6),
        .function_input(fn6), .alu_op(op6), .alu_control(ac6),
        .out_valid(ov6), .out_ready(or6), .multi_cycle(mc6),
        .illegal(ill6), .busy_count(bc6)
    );

    typedef struct {
        logic [1:0] op;
        logic [2:0] fn;
        logic [2:0] code;
        logic       ill;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{2'b00, 3'b111, 3'b001, 1'b0};
        vecs[1]  = '{2'b01, 3'b110, 3'b010, 1'b0};
        vecs[2]  = '{2'b11, 3'b011, 3'b001, 1'b0};
        vecs[3]  = '{2'b10, 3'b000, 3'b001, 1'b0};
        vecs[4]  = '{2'b10, 3'b010, 3'b010, 1'b0};
        vecs[5]  = '{2'b10, 3'b100, 3'b011, 1'b0};
        vecs[6]  = '{2'b10, 3'b101, 3'b100, 1'b0};
        vecs[7]  = '{2'b10, 3'b001, 3'b000, 1'b1};
        vecs[8]  = '{2'b10, 3'b011, 3'b000, 1'b1};
        vecs[9]  = '{2'b01, 3'b000, 3'b010, 1'b0};
        vecs[10] = '{2'b10, 3'b101, 3'b100, 1'b0};

        in_valid = 0; out_ready = 1; function_input = 0; alu_op = 0;
        iv6 = 0; or6 = 1; fn6 = 0; op6 = 0;

        // Reset values
        #1 reset = 1;
        #1;
        check("rst_code", 32'(alu_control), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_multi", 32'(multi_cycle), 0);
        check("rst_busy", 32'(busy_count), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        step();
        reset = 0;

        // Back-to-back single-cycle decode table
        in_valid = 1;
        for (int i = 0; i < 11; i++) begin
            alu_op = vecs[i].op;
            function_input = vecs[i].fn;
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 1);
            step();
            check($sformatf("tbl%0d_code", i), 32'(alu_control), 32'(vecs[i].code));
            check($sformatf("tbl%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
            check($sformatf("tbl%0d_valid", i), 32'(out_valid), 1);
        end
        in_valid = 0;
        step();
        check("drain_valid", 32'(out_valid), 0);
        check("drain_code_hold", 32'(alu_control), 3'b100);

        // MUL: 3 EXEC cycles then valid
        alu_op = 2'b10; function_input = 3'b110; in_valid = 1;
        step();
        in_valid = 0; function_input = 3'b000; alu_op = 2'b01;
        for (int j = 3; j >= 1; j--) begin
            check($sformatf("mul_busy%0d", j), 32'(busy_count), 32'(j));
            check($sformatf("mul_multi%0d", j), 32'(multi_cycle), 1);
            check($sformatf("mul_in_ready%0d", j), 32'(in_ready), 0);
            check($sformatf("mul_valid%0d", j), 32'(out_valid), 0);
            step();
        end
        check("mul_done_valid", 32'(out_valid), 1);
        check("mul_done_code", 32'(alu_control), 3'b101);
        check("mul_done_multi", 32'(multi_cycle), 0);
        check("mul_done_busy", 32'(busy_count), 0);
        step();
        check("mul_xfer_valid", 32'(out_valid), 0);

        // DIV: 7 EXEC cycles then valid
        alu_op = 2'b10; function_input = 3'b111; in_valid = 1;
        step();
        in_valid = 0;
        for (int j = 7; j >= 1; j--) begin
            check($sformatf("div_busy%0d", j), 32'(busy_count), 32'(j));
            check($sformatf("div_valid%0d", j), 32'(out_valid), 0);
            step();
        end
        check("div_done_valid", 32'(out_valid), 1);
        check("div_done_code", 32'(alu_control), 3'b110);
        check("div_done_illegal", 32'(illegal), 0);
        step();

        // Back-pressure: ADD held, SUB waits, then transfer+accept in one cycle
        out_ready = 0; alu_op = 2'b00; function_input = 3'b000; in_valid = 1;
        step();
        check("bp_add_valid", 32'(out_valid), 1);
        check("bp_add_code", 32'(alu_control), 3'b001);
        alu_op = 2'b01;
        check("bp_in_ready_low", 32'(in_ready), 0);
        step();
        check("bp_hold_code", 32'(alu_control), 3'b001);
        check("bp_hold_valid", 32'(out_valid), 1);
        out_ready = 1;
        #1;
        check("bp_in_ready_high", 32'(in_ready), 1);
        step();
        check("bp_sub_code", 32'(alu_control), 3'b010);
        check("bp_sub_valid", 32'(out_valid), 1);
        in_valid = 0;
        step();
        check("bp_sub_xfer", 32'(out_valid), 0);

        // Wide function field on the second instance
        op6 = 2'b10; fn6 = 6'b001000; iv6 = 1;
        step();
        check("w6_upper_code", 32'(ac6), 3'b000);
        check("w6_upper_illegal", 32'(ill6), 1);
        check("w6_upper_valid", 32'(ov6), 1);
        op6 = 2'b00;
        step();
        check("w6_add_code", 32'(ac6), 3'b001);
        check("w6_add_illegal", 32'(ill6), 0);
        op6 = 2'b10; fn6 = 6'b000110;
        check("w6_mul_in_ready", 32'(ir6), 1);
        step();
        check("w6_mul1_code", 32'(ac6), 3'b101);
        check("w6_mul1_valid", 32'(ov6), 1);
        check("w6_mul1_multi", 32'(mc6), 0);
        iv6 = 0;
        step();

        // Reset aborts an in-flight DIV
        alu_op = 2'b10; function_input = 3'b111; in_valid = 1;
        step();
        in_valid = 0;
        step();
        step();
        check("abort_busy_pre", 32'(busy_count), 5);
        reset = 1;
        #1;
        check("abort_code", 32'(alu_control), 0);
        check("abort_multi", 32'(multi_cycle), 0);
        check("abort_busy", 32'(busy_count), 0);
        check("abort_valid", 32'(out_valid), 0);
        check("abort_in_ready", 32'(in_ready), 1);
        step();
        step();
        reset = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            check($sformatf("abort_no_valid%0d", j), 32'(out_valid), 0);
        end
        alu_op = 2'b00; in_valid = 1;
        step();
        in_valid = 0;
        check("post_abort_code", 32'(alu_control), 3'b001);
        check("post_abort_valid", 32'(out_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
